// File: rtl/rx_intf_m_axis_pkt.sv
// Packet-oriented AXI-Stream master: buffers accumulator beats in a FWFT FIFO and
// emits one DMA packet (optionally endless, abortable) per rising edge of start_1trans.
module rx_intf_m_axis_pkt #(
    parameter int C_M_AXIS_TDATA_WIDTH   = 64,
    parameter int FIFO_ADDR_BITS         = 9,
    parameter int MAX_BIT_NUM_DMA_SYMBOL = 14,
    parameter int WAIT_COUNT_BITS        = 5,
    parameter int ALMOST_FULL_MARGIN     = 8
) (
    input  logic                                M_AXIS_ACLK,
    input  logic                                M_AXIS_ARESET,
    input  logic                                endless_mode,
    input  logic [WAIT_COUNT_BITS-1:0]          START_COUNT_CFG,
    input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]   M_AXIS_NUM_DMA_SYMBOL,
    input  logic                                start_1trans,
    input  logic                                abort_1trans,
    input  logic [C_M_AXIS_TDATA_WIDTH-1:0]     DATA_FROM_ACC,
    input  logic                                ACC_DATA_READY,
    output logic                                FULLN_TO_ACC,
    output logic                                ALMOST_FULLN_TO_ACC,
    output logic [FIFO_ADDR_BITS:0]             data_count,
    output logic [15:0]                         overflow_count,
    output logic                                busy,
    output logic                                pkt_done,
    output logic                                M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
    output logic                                M_AXIS_TLAST,
    input  logic                                M_AXIS_TREADY
);

    localparam int DEPTH = 2 ** FIFO_ADDR_BITS;
    localparam logic [FIFO_ADDR_BITS:0] AF_LEVEL = (FIFO_ADDR_BITS+1)'(DEPTH - ALMOST_FULL_MARGIN);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SEND} state_t;

    logic [C_M_AXIS_TDATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [FIFO_ADDR_BITS-1:0]         wr_ptr_q, rd_ptr_q;
    logic [FIFO_ADDR_BITS:0]           count_q;
    logic [15:0]                       ovf_q;

    state_t                            state_q, state_d;
    logic                              start_d_q;
    logic [WAIT_COUNT_BITS-1:0]        wait_cnt_q, wait_cnt_d, wait_cfg_q, wait_cfg_d;
    logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] len_q, len_d, beat_q, beat_d;
    logic                              endless_q, endless_d;
    logic                              term_pend_q, term_pend_d;
    logic                              pkt_done_q, pkt_done_d;

    logic empty, full, tvalid, tlast, tx_en, wr_en, start_rise;

    // count never exceeds DEPTH, so its MSB alone flags a full FIFO
    assign empty      = (count_q == '0);
    assign full       = count_q[FIFO_ADDR_BITS];
    assign tvalid     = (state_q == S_SEND) && !empty;
    assign tlast      = tvalid && ((!endless_q && (beat_q == len_q)) || term_pend_q);
    assign tx_en      = tvalid && M_AXIS_TREADY;
    assign wr_en      = ACC_DATA_READY && (!full || tx_en);
    assign start_rise = start_1trans && !start_d_q;

    assign FULLN_TO_ACC        = !full;
    assign ALMOST_FULLN_TO_ACC = (count_q < AF_LEVEL);
    assign data_count          = count_q;
    assign overflow_count      = ovf_q;
    assign busy                = (state_q != S_IDLE);
    assign pkt_done            = pkt_done_q;
    assign M_AXIS_TVALID       = tvalid;
    assign M_AXIS_TLAST        = tlast;
    assign M_AXIS_TSTRB        = '1;
    assign M_AXIS_TDATA        = empty ? '0 : mem_q[rd_ptr_q];

    // NOTE: the storage array has no reset; emptiness is tracked by count_q and TDATA is masked while empty.
    always_ff @(posedge M_AXIS_ACLK) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= DATA_FROM_ACC;
        end
    end

    always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
        if (M_AXIS_ARESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (tx_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (wr_en && !tx_en)      count_q <= count_q + 1'b1;
            else if (!wr_en && tx_en) count_q <= count_q - 1'b1;
            if (ACC_DATA_READY && !wr_en && (ovf_q != 16'hFFFF)) ovf_q <= ovf_q + 16'd1;
        end
    end

    always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
        if (M_AXIS_ARESET) begin
            state_q     <= S_IDLE;
            start_d_q   <= 1'b0;
            wait_cnt_q  <= '0;
            wait_cfg_q  <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            endless_q   <= 1'b0;
            term_pend_q <= 1'b0;
            pkt_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_d_q   <= start_1trans;
            wait_cnt_q  <= wait_cnt_d;
            wait_cfg_q  <= wait_cfg_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            endless_q   <= endless_d;
            term_pend_q <= term_pend_d;
            pkt_done_q  <= pkt_done_d;
        end
    end

    // NOTE: every signal gets its hold value first so no path through the case can infer a latch.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        wait_cfg_d  = wait_cfg_q;
        len_d       = len_q;
        beat_d      = beat_q;
        endless_d   = endless_q;
        term_pend_d = term_pend_q;
        pkt_done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_rise) begin
                    len_d       = M_AXIS_NUM_DMA_SYMBOL;
                    endless_d   = endless_mode;
                    wait_cfg_d  = START_COUNT_CFG;
                    wait_cnt_d  = '0;
                    beat_d      = '0;
                    term_pend_d = 1'b0;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort_1trans) begin
                    state_d    = S_IDLE;
                    pkt_done_d = 1'b1;
                end else if (wait_cnt_q == wait_cfg_q) begin
                    state_d = S_SEND;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_SEND: begin
                // abort only arms TLAST for the next beat; the beat accepted now is unaffected
                if (abort_1trans) term_pend_d = 1'b1;
                if (tx_en) begin
                    beat_d = beat_q + 1'b1;
                    if (tlast) begin
                        state_d     = S_IDLE;
                        pkt_done_d  = 1'b1;
                        term_pend_d = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_rx_intf_m_axis_pkt.sv
// Self-checking bench for rx_intf_m_axis_pkt: table-driven packet vectors plus
// hand-written sequences for backpressure, fill/overflow, abort and mid-packet reset.
module tb_rx_intf_m_axis_pkt;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        endless_mode = 1'b0;
    logic [4:0]  start_cfg = '0;
    logic [13:0] num_sym = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [63:0] acc_data = '0;
    logic        acc_ready = 1'b0;
    logic        tready = 1'b0;

    logic        fulln, almost_fulln, busy, pkt_done, tvalid, tlast;
    logic [9:0]  data_count;
    logic [15:0] overflow_count;
    logic [63:0] tdata;
    logic [7:0]  tstrb;

    rx_intf_m_axis_pkt dut (
        .M_AXIS_ACLK           (clk),
        .M_AXIS_ARESET         (rst),
        .endless_mode          (endless_mode),
        .START_COUNT_CFG       (start_cfg),
        .M_AXIS_NUM_DMA_SYMBOL (num_sym),
        .start_1trans          (start),
        .abort_1trans          (abort),
        .DATA_FROM_ACC         (acc_data),
        .ACC_DATA_READY        (acc_ready),
        .FULLN_TO_ACC          (fulln),
        .ALMOST_FULLN_TO_ACC   (almost_fulln),
        .data_count            (data_count),
        .overflow_count        (overflow_count),
        .busy                  (busy),
        .pkt_done              (pkt_done),
        .M_AXIS_TVALID         (tvalid),
        .M_AXIS_TDATA          (tdata),
        .M_AXIS_TSTRB          (tstrb),
        .M_AXIS_TLAST          (tlast),
        .M_AXIS_TREADY         (tready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cfg;
        int num;
        int prefill;
        bit disturb;
        int exp_delay;
        int exp_beats;
        int exp_left;
    } pkt_vec_t;

    pkt_vec_t    vecs [5];
    int          checks = 0;
    int          failures = 0;
    logic [63:0] base3 = 64'hC3C3_0000_0000_0000;
    longint      exp_idx = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0; abort = 1'b0; acc_ready = 1'b0; tready = 1'b0; endless_mode = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        step();
    endtask

    task automatic prefill(input int n, input logic [63:0] base);
        for (int i = 0; i < n; i++) begin
            acc_ready = 1'b1;
            acc_data  = base + 64'(i);
            step();
        end
        acc_ready = 1'b0;
    endtask

    task automatic run_pkt(input pkt_vec_t v, input int idx);
        logic [63:0] base;
        int delay;
        int beats;
        bit got_last;
        base = 64'(idx + 1) << 48;
        do_reset();
        prefill(v.prefill, base);
        check($sformatf("v%0d_prefill_count", idx), 64'(data_count), 64'(v.prefill));
        if (v.disturb) begin
            abort = 1'b1;
            step();
            abort = 1'b0;
            check("t5_idle_abort_busy", 64'(busy), 64'd0);
            check("t5_idle_abort_done", 64'(pkt_done), 64'd0);
        end
        start_cfg = v.cfg[4:0];
        num_sym   = v.num[13:0];
        endless_mode = 1'b0;
        tready = 1'b1;
        start  = 1'b1;
        step();
        check($sformatf("v%0d_busy_wait", idx), 64'(busy), 64'd1);
        if (v.disturb) begin
            num_sym = '0; start_cfg = 5'd0; endless_mode = 1'b1; start = 1'b0;
        end
        delay = 0;
        while (!tvalid && delay < 100) begin
            if (v.disturb) start = ~start;
            step();
            delay++;
        end
        check($sformatf("v%0d_delay", idx), 64'(delay), 64'(v.exp_delay));
        beats = 0;
        got_last = 1'b0;
        for (int g = 0; g < 200 && !got_last; g++) begin
            if (tvalid) begin
                check($sformatf("v%0d_tdata", idx), tdata, base + 64'(beats));
                check($sformatf("v%0d_tlast", idx), 64'(tlast), 64'(beats == v.exp_beats - 1));
                if (tlast) got_last = 1'b1;
                beats++;
            end
            if (v.disturb) start = ~start;
            step();
        end
        check($sformatf("v%0d_beats", idx), 64'(beats), 64'(v.exp_beats));
        check($sformatf("v%0d_busy_end", idx), 64'(busy), 64'd0);
        check($sformatf("v%0d_pkt_done", idx), 64'(pkt_done), 64'd1);
        check($sformatf("v%0d_left", idx), 64'(data_count), 64'(v.exp_left));
        start = 1'b0;
        endless_mode = 1'b0;
        step();
        check($sformatf("v%0d_done_pulse", idx), 64'(pkt_done), 64'd0);
        check($sformatf("v%0d_idle", idx), 64'(busy), 64'd0);
    endtask

    task automatic endless_abort(input int abort_after, input bit coincide, input int exp_total);
        int beats;
        bit aborted;
        bit done;
        beats = 0; aborted = 1'b0; done = 1'b0;
        endless_mode = 1'b1;
        start_cfg = 5'd0;
        num_sym = '0;
        start = 1'b1;
        for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
            abort  = 1'b0;
            tready = 1'b1;
            if (!aborted && beats == abort_after) begin
                abort = 1'b1;
                aborted = 1'b1;
                tready = coincide;
            end
            #1;
            if (tvalid && tready) begin
                check("t4_tdata", tdata, base3 + 64'(exp_idx));
                check("t4_tlast", 64'(tlast), 64'(aborted && !abort));
                exp_idx++;
                beats++;
                if (tlast) done = 1'b1;
            end
            step();
        end
        abort = 1'b0;
        check("t4_terminated", 64'(done), 64'd1);
        check("t4_beats", 64'(beats), 64'(exp_total));
        check("t4_busy_end", 64'(busy), 64'd0);
        check("t4_pkt_done", 64'(pkt_done), 64'd1);
        start = 1'b0;
        endless_mode = 1'b0;
        step();
        check("t4_done_pulse", 64'(pkt_done), 64'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats;
        bit done;
        bit prev_stall;
        logic [63:0] prev_data;
        logic prev_last;
        int written;
        logic [63:0] base2;

        vecs[0] = '{3, 7, 16, 1'b0, 4, 8, 8};
        vecs[1] = '{0, 0, 3, 1'b0, 1, 1, 2};
        vecs[2] = '{10, 4, 5, 1'b0, 11, 5, 0};
        vecs[3] = '{31, 2, 4, 1'b0, 32, 3, 1};
        vecs[4] = '{2, 3, 8, 1'b1, 3, 4, 4};

        do_reset();
        check("rst_tvalid", 64'(tvalid), 64'd0);
        check("rst_tlast", 64'(tlast), 64'd0);
        check("rst_tdata", tdata, 64'd0);
        check("rst_tstrb", 64'(tstrb), 64'hFF);
        check("rst_count", 64'(data_count), 64'd0);
        check("rst_ovf", 64'(overflow_count), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(pkt_done), 64'd0);
        check("rst_fulln", 64'(fulln), 64'd1);
        check("rst_afulln", 64'(almost_fulln), 64'd1);

        for (int i = 0; i < 5; i++) run_pkt(vecs[i], i);

        // random backpressure with concurrent trickle writes
        do_reset();
        base2 = 64'hB2B2_0000_0000_0000;
        start_cfg = 5'd0; num_sym = 14'd31; endless_mode = 1'b0; start = 1'b1;
        beats = 0; done = 1'b0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0; written = 0;
        for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
            acc_ready = ((cyc % 2) == 0) && (written < 32);
            acc_data  = base2 + 64'(written);
            if (acc_ready) written++;
            tready = 1'($urandom_range(0, 1));
            #1;
            if (prev_stall) begin
                check("t2_hold_valid", 64'(tvalid), 64'd1);
                check("t2_hold_data", tdata, prev_data);
                check("t2_hold_last", 64'(tlast), 64'(prev_last));
            end
            if (tvalid && tready) begin
                check("t2_tdata", tdata, base2 + 64'(beats));
                check("t2_tlast", 64'(tlast), 64'(beats == 31));
                beats++;
                if (tlast) done = 1'b1;
            end
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            prev_last  = tlast;
            step();
        end
        acc_ready = 1'b0;
        start = 1'b0;
        check("t2_beats", 64'(beats), 64'd32);
        check("t2_busy_end", 64'(busy), 64'd0);
        check("t2_pkt_done", 64'(pkt_done), 64'd1);
        check("t2_left", 64'(data_count), 64'd0);

        // fill to full plus five dropped writes
        do_reset();
        for (int i = 0; i < 517; i++) begin
            acc_ready = 1'b1;
            acc_data  = base3 + 64'(i);
            step();
            if (i == 502) check("t3_afulln_503", 64'(almost_fulln), 64'd1);
            if (i == 503) check("t3_afulln_504", 64'(almost_fulln), 64'd0);
            if (i == 510) check("t3_fulln_511", 64'(fulln), 64'd1);
            if (i == 511) begin
                check("t3_fulln_512", 64'(fulln), 64'd0);
                check("t3_count_512", 64'(data_count), 64'd512);
            end
        end
        acc_ready = 1'b0;
        check("t3_ovf", 64'(overflow_count), 64'd5);
        check("t3_count_end", 64'(data_count), 64'd512);

        // endless packets terminated by abort, stalled and coinciding with a beat
        exp_idx = 0;
        endless_abort(100, 1'b0, 101);
        endless_abort(10, 1'b1, 12);
        check("t4_left", 64'(data_count), 64'd399);
        check("t4_ovf_kept", 64'(overflow_count), 64'd5);

        // reset in the middle of SEND
        endless_mode = 1'b1; start_cfg = 5'd0; tready = 1'b1; start = 1'b1;
        repeat (4) step();
        check("t6_pre_tvalid", 64'(tvalid), 64'd1);
        rst = 1'b1;
        #1;
        check("t6_tvalid", 64'(tvalid), 64'd0);
        check("t6_tlast", 64'(tlast), 64'd0);
        check("t6_count", 64'(data_count), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_ovf", 64'(overflow_count), 64'd0);
        check("t6_fulln", 64'(fulln), 64'd1);
        check("t6_done", 64'(pkt_done), 64'd0);
        start = 1'b0; endless_mode = 1'b0; tready = 1'b0;
        step();
        rst = 1'b0;
        step();
        check("t6_after_busy", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
